bist_pattern_controller: RTL
============================

Name: bist_pattern_controller

Overview:
- Sequential built-in self-test front end for the fault-simulation benchmark circuits.
- Sits on the opposite side of the circuit-under-test (CUT) interface from the gate-level designs:
  - drives the CUT's primary inputs with an LFSR pattern stream;
  - compacts the CUT's primary outputs into a MISR signature.
- At end of run, compares the signature against a golden value and reports pass/fail.
- The CUT is purely combinational. Its response to pat_out is sampled on the same clock edge that advances the pattern.

Parameters:
- PAT_W, 9: width of pattern bus. Sized for a[3:0], b, c, d[2:0]. Fixed at 9 for this revision, because the LFSR polynomial is width-specific.
- RSP_W, 2: width of response bus (f[1:0]). Legal range 1..MISR_W.
- MISR_W, 8: signature register width.
- SEED, 9'h001: LFSR load value. All-zero is replaced by 9'h001.
- PATTERN_COUNT, 255: number of patterns applied per run. Legal range 1..511.
- GOLDEN_SIG, 8'h00: expected signature.

Ports:
- clk, input, 1: clock, rising-edge active.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: begin run. Sampled only in IDLE or DONE.
- hold, input, 1: freeze the run while high (APPLY only).
- rsp_in, input, RSP_W: CUT outputs for the current pat_out.
- pat_out, output, PAT_W: CUT input pattern (registered).
- busy, output, 1: high in APPLY.
- done, output, 1: high in DONE. Held until next start or reset.
- pass, output, 1: signature == GOLDEN_SIG. Valid while done.
- signature, output, MISR_W: current MISR contents.

Behaviour:
- Reset values:
  - state = IDLE;
  - pat_out = SEED (nonzero-corrected);
  - signature = 0;
  - busy = done = pass = 0;
  - pattern counter = 0.
- States are IDLE, APPLY and DONE.
- IDLE:
  - start=1 → load LFSR with SEED, clear MISR and counter, go to APPLY. busy rises the next cycle.
  - start=0 → remain in IDLE.
- LFSR (Fibonacci, polynomial x^9+x^5+1, period 511):
  - fb = q[8]^q[4];
  - next = {q[7:0], fb}.
- MISR (polynomial x^8+x^6+x^5+x^4+1):
  - fb = m[7]^m[5]^m[4]^m[3];
  - next = {m[6:0], fb} ^ zero-extended rsp_in.
- APPLY, each cycle with hold=0:
  - MISR absorbs rsp_in;
  - LFSR advances;
  - counter increments.
- APPLY with hold=1: LFSR, MISR and counter all frozen. pat_out is stable, so CUT settling time can be extended.
- End of run:
  - On the non-held APPLY cycle where counter == PATTERN_COUNT-1, the final absorb happens and the next state is DONE.
  - Exactly PATTERN_COUNT patterns are absorbed, starting with SEED.
  - Run latency = PATTERN_COUNT + held cycles, start edge → done.
- DONE entry:
  - busy=0, done=1;
  - pass registered as (MISR next value == GOLDEN_SIG);
  - pat_out keeps its last advanced value, signature is frozen.
- DONE with start=1: behaves exactly as start in IDLE (restart). done and pass clear on the cycle busy rises.
- start is ignored while in APPLY.
- hold is ignored outside APPLY.
- PATTERN_COUNT=1: a single APPLY cycle, then DONE.
- rst asserted mid-run: immediate return to reset values. No partial signature is retained.
- Counter width = clog2(PATTERN_COUNT+1). No wrap is possible within a legal run.

Decomposition:
- Shared package bist_pkg contains:
  - state enum (IDLE, APPLY, DONE);
  - LFSR and MISR tap constants;
  - a function for the SEED zero-correction.
- One sub-module, bist_misr:
  - parameterised on MISR_W and RSP_W;
  - ports clk, rst, clr, en, rsp_in, sig.
- The LFSR stays inline in the controller.

Test Plan:
- Reset, then idle: pat_out=9'h001, signature=8'h00, busy=done=pass=0. No change with start=0 held for 10 cycles.
- start pulse with PATTERN_COUNT=255 and rsp_in tied to 0:
  - pat_out sequence 001, 002, 004, 008, 010, 021, …;
  - signature stays 00;
  - done rises exactly 255 cycles after busy;
  - pass=1 when GOLDEN_SIG=00.
- PATTERN_COUNT=2, rsp_in=2'b11 then 2'b00: signature 03 then 06, done=1. GOLDEN_SIG=06 → pass=1; GOLDEN_SIG=07 → pass=0.
- hold asserted for 3 cycles mid-run: pat_out and signature frozen during the hold. Final signature is identical to the unheld run; done is delayed by exactly 3 cycles.
- rst pulsed at pattern 100 of 255: all outputs return to reset values immediately. A following start yields the same signature as a clean run.
- start asserted during APPLY: ignored, run length unchanged. start in DONE restarts: done drops and busy rises the next cycle.
- Connected to the 9-input/2-output benchmark netlist: the fault-free signature equals GOLDEN_SIG from the reference model. A stuck-at-0 injected on the f[0] driver yields pass=0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern controller: FSM states,
// LFSR/MISR tap masks and the seed zero-correction helper.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } bist_state_e;

   localparam int         LFSR_W    = 9;
   // x^9 + x^5 + 1 : feedback from q[8] and q[4]
   localparam logic [8:0] LFSR_TAPS = 9'h110;
   // x^8 + x^6 + x^5 + x^4 + 1 : feedback from m[7], m[5], m[4], m[3]
   localparam logic [7:0] MISR_TAPS = 8'hB8;

   function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] seed);
      return (seed == '0) ? 9'h001 : seed;
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts with polynomial feedback and
// folds the zero-extended response word into the low bits each enabled cycle.
module bist_misr
   import bist_pkg::*;
#(
   parameter int                MISR_W = 8,
   parameter int                RSP_W  = 2,
   parameter logic [MISR_W-1:0] TAPS   = MISR_W'(MISR_TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [RSP_W-1:0]  rsp_in,
   output logic [MISR_W-1:0] sig
);

   logic [MISR_W-1:0] r_sig;
   logic [MISR_W-1:0] w_next;

   assign w_next = {r_sig[MISR_W-2:0], ^(r_sig & TAPS)} ^ MISR_W'(rsp_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sig <= '0;
      end else if (clr) begin
         r_sig <= '0;
      end else if (en) begin
         r_sig <= w_next;
      end
   end

   assign sig = r_sig;

endmodule

// File: rtl/bist_pattern_controller.sv
// BIST front end: drives the CUT from a 9-bit LFSR, compacts its responses
// into a MISR and compares the final signature against a golden value.
//
// state | meaning
// IDLE  | waiting for start; LFSR holds seed
// APPLY | one pattern absorbed per cycle unless hold is high
// DONE  | signature frozen, pass valid; start restarts the run
module bist_pattern_controller
   import bist_pkg::*;
#(
   parameter int                PAT_W         = 9,
   parameter int                RSP_W         = 2,
   parameter int                MISR_W        = 8,
   parameter logic [PAT_W-1:0]  SEED          = 9'h001,
   parameter int                PATTERN_COUNT = 255,
   parameter logic [MISR_W-1:0] GOLDEN_SIG    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   input  logic [RSP_W-1:0]  rsp_in,
   output logic [PAT_W-1:0]  pat_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [MISR_W-1:0] signature
);

   localparam int                CNT_W    = $clog2(PATTERN_COUNT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PATTERN_COUNT - 1);
   localparam logic [PAT_W-1:0]  SEED_OK  = fix_seed(SEED);
   localparam logic [MISR_W-1:0] W_TAPS   = MISR_W'(MISR_TAPS);

   bist_state_e       r_state;
   bist_state_e       w_state_nxt;
   logic              w_load;
   logic              w_step;
   logic              w_last;
   logic [PAT_W-1:0]  r_lfsr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_pass;
   logic [MISR_W-1:0] w_sig;
   logic [MISR_W-1:0] w_sig_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = APPLY;
            end
         end
         APPLY: begin
            if (!hold) begin
               w_step = 1'b1;
               if (r_cnt == CNT_LAST) begin
                  w_last      = 1'b1;
                  w_state_nxt = DONE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Look-ahead of the MISR update so pass is registered together with the final absorb.
   assign w_sig_nxt = {w_sig[MISR_W-2:0], ^(w_sig & W_TAPS)} ^ MISR_W'(rsp_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= SEED_OK;
         r_cnt  <= '0;
         r_pass <= 1'b0;
      end else if (w_load) begin
         r_lfsr <= SEED_OK;
         r_cnt  <= '0;
         r_pass <= 1'b0;
      end else if (w_step) begin
         r_lfsr <= lfsr_next(r_lfsr);
         r_cnt  <= r_cnt + 1'b1;
         if (w_last) begin
            r_pass <= (w_sig_nxt == GOLDEN_SIG);
         end
      end
   end

   bist_misr #(
      .MISR_W (MISR_W),
      .RSP_W  (RSP_W),
      .TAPS   (W_TAPS)
   ) u_misr (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_load),
      .en     (w_step),
      .rsp_in (rsp_in),
      .sig    (w_sig)
   );

   assign pat_out   = r_lfsr;
   assign busy      = (r_state == APPLY);
   assign done      = (r_state == DONE);
   assign pass      = r_pass;
   assign signature = w_sig;

endmodule
